spi_sts_sync: RTL and testbench

Returns status and sticky error information from the spi_clk domain to the AXI clock domain. It is the counterpart of the config path, which carries AXI-side configuration into spi_clk. Multi-bit status is moved as a coherent snapshot using a 4-phase req/ack handshake. The block sits between the SPI core logic and axi_shim_cfg's status/readback registers.

---
 rtl/lcb_sts_pkg.sv | 26 ++
 rtl/spi_sts_sync_if.sv | 24 ++
 rtl/bit_sync.sv | 18 +
 rtl/spi_sts_sync.sv | 141 ++++++++++++++
 tb/tb_spi_sts_sync.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/lcb_sts_pkg.sv
// Shared definitions for the spi_clk -> AXI status return path: source FSM
// states, default widths and the legal synchronizer depth range.
package lcb_sts_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_NACK = 2'd3
    } src_state_e;

    localparam int STS_WIDTH_DEF      = 16;
    localparam int ERR_WIDTH_DEF      = 8;
    localparam int SYNC_DEPTH_DEF     = 2;
    localparam int SYNC_DEPTH_MIN     = 2;
    localparam int SYNC_DEPTH_MAX     = 4;
    localparam int REFRESH_CYCLES_DEF = 1024;

    // Out-of-range depths are pulled back into the supported window.
    function automatic int clamp_sync_depth(input int d);
        if (d < SYNC_DEPTH_MIN) return SYNC_DEPTH_MIN;
        if (d > SYNC_DEPTH_MAX) return SYNC_DEPTH_MAX;
        return d;
    endfunction

endpackage

// File: rtl/spi_sts_sync_if.sv
// Status/error bundle between the SPI core (spi_clk) and the AXI register
// block (clk). master = the surrounding logic, slave = spi_sts_sync.
interface spi_sts_sync_if #(
    parameter int STS_WIDTH = lcb_sts_pkg::STS_WIDTH_DEF,
    parameter int ERR_WIDTH = lcb_sts_pkg::ERR_WIDTH_DEF
);
    logic [STS_WIDTH-1:0] sts_spi;
    logic [ERR_WIDTH-1:0] err_spi;
    logic                 busy_spi;
    logic [STS_WIDTH-1:0] sts_axi;
    logic [ERR_WIDTH-1:0] err_axi;
    logic [ERR_WIDTH-1:0] err_clr;
    logic                 upd_axi;

    modport master (
        output sts_spi, err_spi, err_clr,
        input  busy_spi, sts_axi, err_axi, upd_axi
    );

    modport slave (
        input  sts_spi, err_spi, err_clr,
        output busy_spi, sts_axi, err_axi, upd_axi
    );
endinterface

// File: rtl/bit_sync.sv
// Plain N-flop single-bit synchronizer with asynchronous active-high reset.
module bit_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [N-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[N-2:0], d_i};
    end

    assign q_o = sync_q[N-1];
endmodule

// File: rtl/spi_sts_sync.sv
// Moves a coherent status/error snapshot from spi_clk to clk via 4-phase req/ack.
// Optional heartbeat refresh: define SPI_STS_SYNC_HEARTBEAT_EN.
module spi_sts_sync
    import lcb_sts_pkg::*;
#(
    parameter int STS_WIDTH      = STS_WIDTH_DEF,
    parameter int ERR_WIDTH      = ERR_WIDTH_DEF,
    parameter int SYNC_DEPTH     = SYNC_DEPTH_DEF,
    parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
    input  logic           spi_clk,
    input  logic           rst,
    input  logic           clk,
    spi_sts_sync_if.slave  bus
);
    localparam int SYNC_N = clamp_sync_depth(SYNC_DEPTH);

    // ---------------- source side (spi_clk) ----------------
    src_state_e           state_q;
    logic                 req_q;
    logic                 ack_s;
    logic [STS_WIDTH-1:0] sts_last_q;
    logic [STS_WIDTH-1:0] snap_sts_q;
    logic [ERR_WIDTH-1:0] err_pend_q;
    logic [ERR_WIDTH-1:0] snap_err_q;
    logic                 dirty;
    logic                 hb_due;
    logic                 start;

    assign dirty = (bus.sts_spi != sts_last_q) | (|err_pend_q);
    assign start = (state_q == ST_IDLE) & (dirty | hb_due);

`ifdef SPI_STS_SYNC_HEARTBEAT_EN
    localparam int HB_W = $clog2(REFRESH_CYCLES + 1);
    logic [HB_W-1:0] hb_cnt_q;

    assign hb_due = (hb_cnt_q == '0);

    // Counts only while idle, so the heartbeat period is REFRESH_CYCLES plus one round trip.
    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst)                     hb_cnt_q <= HB_W'(REFRESH_CYCLES - 1);
        else if (start)              hb_cnt_q <= HB_W'(REFRESH_CYCLES - 1);
        else if (state_q == ST_IDLE) hb_cnt_q <= hb_cnt_q - 1'b1;
    end
`else
    logic unused_refresh;
    assign unused_refresh = |REFRESH_CYCLES;
    assign hb_due         = 1'b0;
`endif

    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            sts_last_q <= '0;
            snap_sts_q <= '0;
            err_pend_q <= '0;
            snap_err_q <= '0;
        end else begin
            err_pend_q <= err_pend_q | bus.err_spi;
            case (state_q)
                ST_IDLE: begin
                    if (dirty || hb_due) begin
                        snap_sts_q <= bus.sts_spi;
                        snap_err_q <= err_pend_q;
                        sts_last_q <= bus.sts_spi;
                        // Events arriving on the snapshot edge ride the next transfer.
                        err_pend_q <= bus.err_spi;
                        req_q      <= 1'b1;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: state_q <= ST_WAIT_ACK;
                ST_WAIT_ACK: begin
                    if (ack_s) begin
                        req_q   <= 1'b0;
                        state_q <= ST_WAIT_NACK;
                    end
                end
                ST_WAIT_NACK: begin
                    if (!ack_s) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_spi = (state_q != ST_IDLE);

    // ---------------- destination side (clk) ----------------
    logic                 req_s;
    logic                 req_s_q;
    logic                 ack_q;
    logic                 upd_q;
    logic [STS_WIDTH-1:0] sts_axi_q;
    logic [ERR_WIDTH-1:0] err_axi_q;
    logic                 req_rise;
    logic                 req_fall;

    bit_sync #(.N(SYNC_N)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d_i (req_q),
        .q_o (req_s)
    );

    bit_sync #(.N(SYNC_N)) u_ack_sync (
        .clk (spi_clk),
        .rst (rst),
        .d_i (ack_q),
        .q_o (ack_s)
    );

    assign req_rise = req_s & ~req_s_q;
    assign req_fall = ~req_s & req_s_q;

    // snap_* have been frozen since REQ, so sampling them on the rise is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_s_q   <= 1'b0;
            ack_q     <= 1'b0;
            upd_q     <= 1'b0;
            sts_axi_q <= '0;
            err_axi_q <= '0;
        end else begin
            req_s_q   <= req_s;
            upd_q     <= req_rise;
            err_axi_q <= (err_axi_q & ~bus.err_clr) | (req_rise ? snap_err_q : '0);
            if (req_rise) begin
                sts_axi_q <= snap_sts_q;
                ack_q     <= 1'b1;
            end else if (req_fall) begin
                ack_q     <= 1'b0;
            end
        end
    end

    assign bus.sts_axi = sts_axi_q;
    assign bus.err_axi = err_axi_q;
    assign bus.upd_axi = upd_q;
endmodule

// File: tb/tb_spi_sts_sync.sv
// Directed bench for spi_sts_sync: snapshot transfer, sticky errors, clears,
// coalescing, mid-handshake reset and heartbeat behaviour.
module tb_spi_sts_sync;
    logic spi_clk = 1'b0;
    logic clk     = 1'b0;
    logic rst     = 1'b1;

    always #5 spi_clk = ~spi_clk;
    always #8 clk     = ~clk;

    spi_sts_sync_if #(.STS_WIDTH(16), .ERR_WIDTH(8)) bus ();

    spi_sts_sync #(
        .STS_WIDTH      (16),
        .ERR_WIDTH      (8),
        .SYNC_DEPTH     (2),
        .REFRESH_CYCLES (64)
    ) dut (
        .spi_clk (spi_clk),
        .rst     (rst),
        .clk     (clk),
        .bus     (bus)
    );

    int   total   = 0;
    int   bad     = 0;
    int   upd_cnt = 0;
    logic [7:0]  cap_err [0:15];
    logic [15:0] cap_sts [0:15];
    time         upd_t   [0:15];

    // Log every capture away from the clk active edge.
    always @(negedge clk) begin
        if (bus.upd_axi === 1'b1) begin
            if (upd_cnt < 16) begin
                cap_err[upd_cnt] = bus.err_axi;
                cap_sts[upd_cnt] = bus.sts_axi;
                upd_t[upd_cnt]   = $time;
            end
            upd_cnt = upd_cnt + 1;
        end
    end

    task automatic test_reset();
        bus.sts_spi = '0;
        bus.err_spi = '0;
        bus.err_clr = '0;
        rst = 1'b1;
        repeat (3) @(posedge spi_clk);
        #1;
        total++; if (bus.busy_spi !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy_spi); end
        total++; if (bus.sts_axi !== 16'h0) begin bad++; $display("FAIL rst_sts got=%h exp=0000", bus.sts_axi); end
        total++; if (bus.err_axi !== 8'h0) begin bad++; $display("FAIL rst_err got=%h exp=00", bus.err_axi); end
        total++; if (bus.upd_axi !== 1'b0) begin bad++; $display("FAIL rst_upd got=%b exp=0", bus.upd_axi); end
        @(negedge spi_clk);
        rst = 1'b0;
        upd_cnt = 0;
        repeat (20) @(posedge spi_clk);
        #1;
        total++; if (upd_cnt !== 0) begin bad++; $display("FAIL idle_no_upd got=%0d exp=0", upd_cnt); end
        total++; if (bus.busy_spi !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", bus.busy_spi); end
    endtask

    task automatic test_status();
        @(posedge spi_clk); #1;
        upd_cnt = 0;
        bus.sts_spi = 16'h00A5;
        repeat (40) @(posedge spi_clk);
        #1;
        total++; if (upd_cnt !== 1) begin bad++; $display("FAIL sts_upd_cnt got=%0d exp=1", upd_cnt); end
        total++; if (bus.sts_axi !== 16'h00A5) begin bad++; $display("FAIL sts_val got=%h exp=00a5", bus.sts_axi); end
        total++; if (bus.err_axi !== 8'h00) begin bad++; $display("FAIL sts_err got=%h exp=00", bus.err_axi); end
        total++; if (bus.busy_spi !== 1'b0) begin bad++; $display("FAIL sts_busy got=%b exp=0", bus.busy_spi); end
    endtask

    task automatic test_err_accum();
        bit seen;
        seen = 1'b0;
        upd_cnt = 0;
        @(posedge spi_clk); #1 bus.err_spi = 8'h01;
        @(posedge spi_clk); #1 bus.err_spi = 8'h00;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge spi_clk); #1;
            if (bus.busy_spi === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL err_busy_seen got=%b exp=1", seen); end
        // One more edge puts the FSM in WAIT_ACK.
        @(posedge spi_clk); #1 bus.err_spi = 8'h04;
        @(posedge spi_clk); #1 bus.err_spi = 8'h00;
        repeat (50) @(posedge spi_clk);
        #1;
        total++; if (upd_cnt !== 2) begin bad++; $display("FAIL err_upd_cnt got=%0d exp=2", upd_cnt); end
        total++; if (cap_err[0] !== 8'h01) begin bad++; $display("FAIL err_first got=%h exp=01", cap_err[0]); end
        total++; if (cap_err[1] !== 8'h05) begin bad++; $display("FAIL err_second got=%h exp=05", cap_err[1]); end
        total++; if (bus.err_axi !== 8'h05) begin bad++; $display("FAIL err_sticky got=%h exp=05", bus.err_axi); end
        total++; if (bus.sts_axi !== 16'h00A5) begin bad++; $display("FAIL err_sts_kept got=%h exp=00a5", bus.sts_axi); end
    endtask

    task automatic test_err_clr();
        @(posedge clk); #1 bus.err_clr = 8'h01;
        @(posedge clk); #1 bus.err_clr = 8'h00;
        @(negedge clk);
        total++; if (bus.err_axi !== 8'h04) begin bad++; $display("FAIL clr_bit0 got=%h exp=04", bus.err_axi); end
        // Hold a clear on bit 2 across a capture of bit 2: capture must win.
        @(posedge clk); #1 bus.err_clr = 8'h04;
        upd_cnt = 0;
        @(posedge spi_clk); #1 bus.err_spi = 8'h04;
        @(posedge spi_clk); #1 bus.err_spi = 8'h00;
        repeat (40) @(posedge spi_clk);
        total++; if (upd_cnt !== 1) begin bad++; $display("FAIL clr_upd_cnt got=%0d exp=1", upd_cnt); end
        total++; if (cap_err[0] !== 8'h04) begin bad++; $display("FAIL clr_set_wins got=%h exp=04", cap_err[0]); end
        @(posedge clk); #1 bus.err_clr = 8'h00;
        @(negedge clk);
        total++; if (bus.err_axi !== 8'h00) begin bad++; $display("FAIL clr_held got=%h exp=00", bus.err_axi); end
    endtask

    task automatic test_coalesce();
        upd_cnt = 0;
        @(posedge spi_clk); #1 bus.sts_spi = 16'h0001;
        @(posedge spi_clk); #1 bus.sts_spi = 16'h0002;
        @(posedge spi_clk); #1 bus.sts_spi = 16'h0003;
        repeat (60) @(posedge spi_clk);
        #1;
        total++; if (upd_cnt !== 2) begin bad++; $display("FAIL coal_upd_cnt got=%0d exp=2", upd_cnt); end
        total++; if (cap_sts[0] !== 16'h0001) begin bad++; $display("FAIL coal_first got=%h exp=0001", cap_sts[0]); end
        total++; if (bus.sts_axi !== 16'h0003) begin bad++; $display("FAIL coal_final got=%h exp=0003", bus.sts_axi); end
    endtask

    task automatic test_rst_mid();
        bit seen;
        seen = 1'b0;
        @(posedge spi_clk); #1 bus.sts_spi = 16'h0055;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge spi_clk); #1;
            if (bus.busy_spi === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rmid_busy_seen got=%b exp=1", seen); end
        @(posedge spi_clk); #1 bus.err_spi = 8'h80;
        @(posedge spi_clk); #1 bus.err_spi = 8'h00;
        rst = 1'b1;
        #1;
        total++; if (bus.sts_axi !== 16'h0) begin bad++; $display("FAIL rmid_sts got=%h exp=0000", bus.sts_axi); end
        total++; if (bus.err_axi !== 8'h0) begin bad++; $display("FAIL rmid_err got=%h exp=00", bus.err_axi); end
        total++; if (bus.upd_axi !== 1'b0) begin bad++; $display("FAIL rmid_upd got=%b exp=0", bus.upd_axi); end
        total++; if (bus.busy_spi !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", bus.busy_spi); end
        repeat (3) @(posedge spi_clk);
        @(negedge spi_clk);
        rst = 1'b0;
        upd_cnt = 0;
        repeat (40) @(posedge spi_clk);
        #1;
        total++; if (upd_cnt !== 1) begin bad++; $display("FAIL rpost_upd_cnt got=%0d exp=1", upd_cnt); end
        total++; if (bus.sts_axi !== 16'h0055) begin bad++; $display("FAIL rpost_sts got=%h exp=0055", bus.sts_axi); end
        total++; if (bus.err_axi !== 8'h00) begin bad++; $display("FAIL rpost_err_dropped got=%h exp=00", bus.err_axi); end
        total++; if (bus.busy_spi !== 1'b0) begin bad++; $display("FAIL rpost_busy got=%b exp=0", bus.busy_spi); end
    endtask

    task automatic test_heartbeat();
        upd_cnt = 0;
        repeat (500) @(posedge spi_clk);
        #1;
`ifdef SPI_STS_SYNC_HEARTBEAT_EN
        total++; if (upd_cnt < 4) begin bad++; $display("FAIL hb_cnt got=%0d exp>=4", upd_cnt); end
        for (int i = 1; i < 4 && i < upd_cnt; i++) begin
            // 64 idle cycles plus one round trip (a handful of cycles each way).
            time gap;
            gap = (upd_t[i] - upd_t[i-1]) / 10;
            total++;
            if (gap < 66 || gap > 100) begin
                bad++; $display("FAIL hb_gap%0d got=%0d exp=66..100", i, gap);
            end
        end
        total++; if (bus.sts_axi !== 16'h0055) begin bad++; $display("FAIL hb_sts got=%h exp=0055", bus.sts_axi); end
`else
        total++; if (upd_cnt !== 0) begin bad++; $display("FAIL hb_none got=%0d exp=0", upd_cnt); end
        total++; if (bus.busy_spi !== 1'b0) begin bad++; $display("FAIL hb_busy got=%b exp=0", bus.busy_spi); end
`endif
    endtask

    initial begin
        bus.sts_spi = '0;
        bus.err_spi = '0;
        bus.err_clr = '0;
        test_reset();
        test_status();
        test_err_accum();
        test_err_clr();
        test_coalesce();
        test_rst_mid();
        test_heartbeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
